// File: rtl/regfile_mp.sv
// regfile_mp: NREAD-read, dual-write register file with a per-register busy scoreboard and a post-reset clear sweep.
// Optional same-cycle write forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    ready,
   output logic                    dbg_state,
   input  logic [NREAD*ADDR_W-1:0] raddr,
   output logic [NREAD*DATA_W-1:0] rdata,
   output logic [NREAD-1:0]        rbusy,
   input  logic                    we0,
   input  logic                    we1,
   input  logic [ADDR_W-1:0]       waddr0,
   input  logic [ADDR_W-1:0]       waddr1,
   input  logic [DATA_W-1:0]       wdata0,
   input  logic [DATA_W-1:0]       wdata1,
   input  logic                    set_en,
   input  logic [ADDR_W-1:0]       set_addr
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = '1;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_ptr;
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [DATA_W-1:0] rf [DEPTH];
   logic              wr0;
   logic              wr1;

   // ready is a level, not a per-transfer handshake: while it is low, writes and sets
   // are dropped and reads return zero/not-busy; once high it stays high until reset.
   assign wr0       = (state == RUN) && we0 && (waddr0 != '0);
   assign wr1       = (state == RUN) && we1 && (waddr1 != '0);
   assign dbg_state = (state == RUN);

   always_comb begin
      busy_nxt = busy;
      if (wr0) busy_nxt[waddr0] = 1'b0;
      if (wr1) busy_nxt[waddr1] = 1'b0;
      // A new producer overrides an older writeback to the same register.
      if (set_en && (set_addr != '0)) busy_nxt[set_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= INIT;
         clr_ptr <= ADDR_W'(1);
         busy    <= '0;
         ready   <= 1'b0;
      end else if (state == INIT) begin
         clr_ptr <= clr_ptr + ADDR_W'(1);
         if (clr_ptr == LAST) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end else begin
         busy <= busy_nxt;
      end
   end

   // Storage carries no reset so it maps to LUT-RAM; the sweep clears it instead.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         rf[clr_ptr] <= '0;
      end else begin
         if (wr0) rf[waddr0] <= wdata0;
         if (wr1) rf[waddr1] <= wdata1;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              b;

      assign ra = raddr[i*ADDR_W +: ADDR_W];

      always_comb begin
         d = rf[ra];
         b = busy[ra];
`ifdef REGFILE_BYPASS_EN
         if (wr1 && (waddr1 == ra)) begin
            d = wdata1;
            b = 1'b0;
         end else if (wr0 && (waddr0 == ra)) begin
            d = wdata0;
            b = 1'b0;
         end
`endif
         if ((state != RUN) || (ra == '0)) begin
            d = '0;
            b = 1'b0;
         end
      end

      assign rdata[i*DATA_W +: DATA_W] = d;
      assign rbusy[i]                  = b;
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, default 2-port/32-entry instance plus a 4-port/8-entry instance.
module tb_regfile_mp;
   localparam int DW = 32;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic        w0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        w1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        s;
      logic [4:0]  sa;
      logic [4:0]  ra;
      logic [31:0] ed;
      logic        eb;
   } step_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ready, dbg_state;
   logic [9:0]    raddr = '0;
   logic [63:0]   rdata;
   logic [1:0]    rbusy;
   logic          we0 = 0, we1 = 0, set_en = 0;
   logic [4:0]    waddr0 = '0, waddr1 = '0, set_addr = '0;
   logic [31:0]   wdata0 = '0, wdata1 = '0;

   logic          s_ready, s_dbg_state;
   logic [11:0]   s_raddr = '0;
   logic [127:0]  s_rdata;
   logic [3:0]    s_rbusy;
   logic          s_we0 = 0, s_we1 = 0, s_set_en = 0;
   logic [2:0]    s_waddr0 = '0, s_waddr1 = '0, s_set_addr = '0;
   logic [31:0]   s_wdata0 = '0, s_wdata1 = '0;

   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] exp_q[$];
   logic [0:0]    expb_q[$];
   logic [DW-1:0] model [32];
   logic [31:0]   busy_m;
   logic [DW-1:0] s_model [8];
   logic [7:0]    s_busy_m;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .reset(reset), .ready(ready), .dbg_state(dbg_state),
      .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
      .wdata0(wdata0), .wdata1(wdata1), .set_en(set_en), .set_addr(set_addr)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(3), .NREAD(4)) dut4 (
      .clk(clk), .reset(reset), .ready(s_ready), .dbg_state(s_dbg_state),
      .raddr(s_raddr), .rdata(s_rdata), .rbusy(s_rbusy),
      .we0(s_we0), .we1(s_we1), .waddr0(s_waddr0), .waddr1(s_waddr1),
      .wdata0(s_wdata0), .wdata1(s_wdata1), .set_en(s_set_en), .set_addr(s_set_addr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; set_en = 0;
      s_we0 = 0; s_we1 = 0; s_set_en = 0;
   endtask

   task automatic clear_models();
      for (int a = 0; a < 32; a++) model[a] = '0;
      for (int a = 0; a < 8; a++) s_model[a] = '0;
      busy_m = '0;
      s_busy_m = '0;
   endtask

   task automatic drive_step(input step_t st);
      we0 = st.w0; waddr0 = st.a0; wdata0 = st.d0;
      we1 = st.w1; waddr1 = st.a1; wdata1 = st.d1;
      set_en = st.s; set_addr = st.sa;
      raddr = {st.ra, st.ra};
   endtask

   // Applies the currently driven write/set inputs to the reference model (called just before the edge).
   task automatic model_commit();
      logic [31:0] nb;
      logic [7:0]  snb;
      nb = busy_m;
      if (we0 && waddr0 != 0) begin model[waddr0] = wdata0; nb[waddr0] = 1'b0; end
      if (we1 && waddr1 != 0) begin model[waddr1] = wdata1; nb[waddr1] = 1'b0; end
      if (set_en && set_addr != 0) nb[set_addr] = 1'b1;
      busy_m = nb;
      snb = s_busy_m;
      if (s_we0 && s_waddr0 != 0) begin s_model[s_waddr0] = s_wdata0; snb[s_waddr0] = 1'b0; end
      if (s_we1 && s_waddr1 != 0) begin s_model[s_waddr1] = s_wdata1; snb[s_waddr1] = 1'b0; end
      if (s_set_en && s_set_addr != 0) snb[s_set_addr] = 1'b1;
      s_busy_m = snb;
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [4:0] a);
      logic [DW-1:0] v;
      v = model[a];
      if (BYP && we0 && waddr0 == a) v = wdata0;
      if (BYP && we1 && waddr1 == a) v = wdata1;
      if (a == 0) v = '0;
      return v;
   endfunction

   function automatic logic exp_bz(input logic [4:0] a);
      logic v;
      v = busy_m[a];
      if (BYP && ((we0 && waddr0 == a) || (we1 && waddr1 == a))) v = 1'b0;
      if (a == 0) v = 1'b0;
      return v;
   endfunction

   task automatic test_reset(input string tag);
      int n, sn;
      logic [DW-1:0] e;
      logic [0:0] eb;
      idle();
      reset = 1;
      tick();
      vectors++;
      if (ready !== 1'b0 || dbg_state !== 1'b0) begin
         miscompares++;
         $display("FAIL %s reset_state: ready=%b state=%b, expected 0 0", tag, ready, dbg_state);
      end
      raddr = {5'd30, 5'd31};
      reset = 0;
      n = 0; sn = 0;
      for (int c = 1; c <= 60 && (n == 0 || sn == 0); c++) begin
         tick();
         if (c == 3) begin
            for (int p = 0; p < 2; p++) begin exp_q.push_back('0); expb_q.push_back(1'b0); end
            for (int p = 0; p < 2; p++) begin
               e = exp_q.pop_front(); eb = expb_q.pop_front(); vectors++;
               if (rdata[p*DW +: DW] !== e || rbusy[p] !== eb[0]) begin
                  miscompares++;
                  $display("FAIL %s init_read p=%0d: rdata=%h rbusy=%b, expected %h %b", tag, p, rdata[p*DW +: DW], rbusy[p], e, eb);
               end
            end
         end
         if (ready === 1'b1 && n == 0) n = c;
         if (s_ready === 1'b1 && sn == 0) sn = c;
      end
      vectors++;
      if (n != 31) begin miscompares++; $display("FAIL %s sweep_len: ready rose at edge %0d (0=never), expected 31", tag, n); end
      vectors++;
      if (sn != 7) begin miscompares++; $display("FAIL %s sweep_len_small: ready rose at edge %0d (0=never), expected 7", tag, sn); end
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(31 - a), 5'(a)};
         for (int p = 0; p < 2; p++) begin exp_q.push_back('0); expb_q.push_back(1'b0); end
         #1;
         for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front(); eb = expb_q.pop_front(); vectors++;
            if (rdata[p*DW +: DW] !== e || rbusy[p] !== eb[0]) begin
               miscompares++;
               $display("FAIL %s cleared a=%0d p=%0d: rdata=%h rbusy=%b, expected %h %b", tag, a, p, rdata[p*DW +: DW], rbusy[p], e, eb);
            end
         end
      end
      clear_models();
   endtask

   task automatic test_junk_then_reset();
      for (int k = 0; k < 16; k++) begin
         we0 = 1; waddr0 = 5'(2*k + 1); wdata0 = $urandom | 32'h1;
         we1 = (k < 15); waddr1 = 5'(2*k + 2); wdata1 = $urandom | 32'h1;
         set_en = 1; set_addr = 5'($urandom_range(1, 31));
         tick();
      end
      idle();
      tick();
      test_reset("after_junk");
   endtask

   task automatic test_mid_reset();
      int n;
      idle();
      reset = 1;
      tick();
      reset = 0;
      repeat (10) tick();
      vectors++;
      if (ready !== 1'b0) begin miscompares++; $display("FAIL mid_sweep_ready: ready=%b, expected 0", ready); end
      reset = 1;
      #1;
      vectors++;
      if (ready !== 1'b0 || dbg_state !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_state: ready=%b state=%b, expected 0 0", ready, dbg_state);
      end
      tick();
      reset = 0;
      n = 0;
      for (int c = 1; c <= 60 && n == 0; c++) begin
         tick();
         if (ready === 1'b1) n = c;
      end
      vectors++;
      if (n != 31) begin miscompares++; $display("FAIL mid_reset_sweep: ready rose at edge %0d (0=never), expected 31", n); end
      clear_models();
   endtask

   task automatic test_collision();
      step_t st [2];
      logic [DW-1:0] e;
      logic [0:0] eb;
      st[0] = '{1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 1'b0, 5'd0, 5'd5,
                BYP ? 32'h22222222 : 32'h0, 1'b0};
      st[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 32'h22222222, 1'b0};
      for (int k = 0; k < 2; k++) begin
         drive_step(st[k]);
         for (int p = 0; p < 2; p++) begin exp_q.push_back(st[k].ed); expb_q.push_back(st[k].eb); end
         #1;
         for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front(); eb = expb_q.pop_front(); vectors++;
            if (rdata[p*DW +: DW] !== e || rbusy[p] !== eb[0]) begin
               miscompares++;
               $display("FAIL collision k=%0d p=%0d: rdata=%h rbusy=%b, expected %h %b", k, p, rdata[p*DW +: DW], rbusy[p], e, eb);
            end
         end
         model_commit();
         tick();
      end
      idle();
   endtask

   task automatic test_reg_zero();
      step_t st [2];
      logic [DW-1:0] e;
      logic [0:0] eb;
      st[0] = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 32'h0, 1'b0};
      st[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0};
      for (int k = 0; k < 2; k++) begin
         drive_step(st[k]);
         for (int p = 0; p < 2; p++) begin exp_q.push_back(st[k].ed); expb_q.push_back(st[k].eb); end
         #1;
         for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front(); eb = expb_q.pop_front(); vectors++;
            if (rdata[p*DW +: DW] !== e || rbusy[p] !== eb[0]) begin
               miscompares++;
               $display("FAIL reg_zero k=%0d p=%0d: rdata=%h rbusy=%b, expected %h %b", k, p, rdata[p*DW +: DW], rbusy[p], e, eb);
            end
         end
         model_commit();
         tick();
      end
      idle();
   endtask

   task automatic test_scoreboard();
      step_t st [9];
      logic [DW-1:0] e;
      logic [0:0] eb;
      st[0] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 32'h0, 1'b0};
      st[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h0, 1'b1};
      st[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h0, 1'b1};
      st[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7,
                BYP ? 32'hA5A5A5A5 : 32'h0, !BYP};
      st[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 32'hA5A5A5A5, 1'b0};
      st[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7,
                BYP ? 32'h12345678 : 32'hA5A5A5A5, 1'b0};
      st[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h12345678, 1'b1};
      st[7] = '{1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7,
                BYP ? 32'h00000001 : 32'h12345678, !BYP};
      st[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h00000001, 1'b0};
      for (int k = 0; k < 9; k++) begin
         drive_step(st[k]);
         for (int p = 0; p < 2; p++) begin exp_q.push_back(st[k].ed); expb_q.push_back(st[k].eb); end
         #1;
         for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front(); eb = expb_q.pop_front(); vectors++;
            if (rdata[p*DW +: DW] !== e || rbusy[p] !== eb[0]) begin
               miscompares++;
               $display("FAIL scoreboard k=%0d p=%0d: rdata=%h rbusy=%b, expected %h %b", k, p, rdata[p*DW +: DW], rbusy[p], e, eb);
            end
         end
         model_commit();
         tick();
      end
      idle();
   endtask

   task automatic test_random();
      logic [4:0] ra [2];
      logic [DW-1:0] e;
      logic [0:0] eb;
      for (int k = 0; k < 80; k++) begin
         we0 = 1'($urandom_range(0, 1)); waddr0 = 5'($urandom_range(0, 31)); wdata0 = $urandom;
         we1 = 1'($urandom_range(0, 1)); waddr1 = 5'($urandom_range(0, 31)); wdata1 = $urandom;
         if (k % 7 == 0) waddr1 = waddr0;
         set_en = 1'($urandom_range(0, 1)); set_addr = 5'($urandom_range(0, 31));
         ra[0] = (k % 3 == 0) ? waddr1 : 5'($urandom_range(0, 31));
         ra[1] = (k % 4 == 0) ? waddr0 : 5'($urandom_range(0, 31));
         raddr = {ra[1], ra[0]};
         for (int p = 0; p < 2; p++) begin exp_q.push_back(exp_rd(ra[p])); expb_q.push_back(exp_bz(ra[p])); end
         #1;
         for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front(); eb = expb_q.pop_front(); vectors++;
            if (rdata[p*DW +: DW] !== e || rbusy[p] !== eb[0]) begin
               miscompares++;
               $display("FAIL random k=%0d p=%0d a=%0d: rdata=%h rbusy=%b, expected %h %b", k, p, ra[p], rdata[p*DW +: DW], rbusy[p], e, eb);
            end
         end
         model_commit();
         tick();
      end
      idle();
   endtask

   task automatic test_port_scaling();
      logic [2:0] ra [4];
      logic [DW-1:0] e;
      logic [0:0] eb;
      for (int k = 0; k < 4; k++) begin
         s_we0 = 1; s_waddr0 = 3'(2*k + 1); s_wdata0 = 32'hC0DE0000 + 32'(2*k + 1);
         s_we1 = (k < 3); s_waddr1 = 3'(2*k + 2); s_wdata1 = 32'hC0DE0000 + 32'(2*k + 2);
         model_commit();
         tick();
      end
      idle();
      for (int k = 0; k < 10; k++) begin
         for (int p = 0; p < 4; p++)
            ra[p] = (k == 0) ? 3'(p + 1) : (k == 1) ? 3'(7 - p) : 3'($urandom_range(0, 7));
         s_set_en = (k >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         s_set_addr = 3'($urandom_range(0, 7));
         s_raddr = {ra[3], ra[2], ra[1], ra[0]};
         for (int p = 0; p < 4; p++) begin
            exp_q.push_back(ra[p] == 0 ? '0 : s_model[ra[p]]);
            expb_q.push_back(ra[p] == 0 ? 1'b0 : s_busy_m[ra[p]]);
         end
         #1;
         for (int p = 0; p < 4; p++) begin
            e = exp_q.pop_front(); eb = expb_q.pop_front(); vectors++;
            if (s_rdata[p*DW +: DW] !== e || s_rbusy[p] !== eb[0]) begin
               miscompares++;
               $display("FAIL port_scaling k=%0d p=%0d a=%0d: rdata=%h rbusy=%b, expected %h %b", k, p, ra[p], s_rdata[p*DW +: DW], s_rbusy[p], e, eb);
            end
         end
         model_commit();
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset("power_on");
      test_junk_then_reset();
      test_mid_reset();
      test_collision();
      test_reg_zero();
      test_scoreboard();
      test_random();
      test_port_scaling();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read, dual-write register file with a per-register busy scoreboard and a post-reset clear sequencer. It replaces the single-issue 2R1W file in the CPU decode/writeback path and serves wider issue: NREAD operand reads, two writeback ports, and pending-write tracking for hazard detection. Storage is a plain array so it maps to LUT-RAM/flops. It is cleared by a sweep after reset instead of a 32-way reset fan-out.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries, entry 0 hardwired to zero
- NREAD, 2, number of read ports (1..4)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- ready  out  1  high once clear sweep is done; reads, writes and sets are valid only when high
- raddr  in  NREAD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  read data, combinational; port i at [i*DATA_W +: DATA_W]
- rbusy  out  NREAD  busy bit of each read address, combinational
- we0, we1  in  1  write enables for the two writeback ports
- waddr0, waddr1  in  ADDR_W  write addresses
- wdata0, wdata1  in  DATA_W  write data
- set_en  in  1  marks set_addr busy, for an issued instruction with a pending result
- set_addr  in  ADDR_W  destination being allocated

## Operation
- FSM states: INIT and RUN. Reset asynchronously forces INIT with clr_ptr=1, busy vector all 0, and ready=0.
- INIT:
  - Each cycle writes 0 to rf[clr_ptr], then clr_ptr increments.
  - When clr_ptr==DEPTH-1 is written, the next state is RUN.
  - we0/we1/set_en are ignored.
  - rdata reads as all zeros and rbusy as 0.
- RUN:
  - weK && waddrK!=0 writes wdataK on the clock edge.
  - When we0 and we1 both target the same address, port 1 wins for both the storage and the forwarded value.
- Read, each port independently:
  - raddr==0 gives 0.
  - Otherwise, with forwarding on, a matching write from port 1 is returned first, then port 0.
  - Otherwise rf[raddr].
- Scoreboard:
  - busy[a] clears when either write port commits to a.
  - busy[a] sets when set_en && set_addr==a.
  - When set and clear hit the same address in the same cycle, set wins: a new producer overrides the older writeback.
  - set_addr==0 is ignored, so busy[0] is always 0.
  - rbusy[i]=busy[raddr_i]. With forwarding on, rbusy[i] is forced to 0 when the forwarded write matches in the same cycle.
- Asserting reset in any state, including mid-sweep, returns to INIT immediately and restarts the sweep from entry 1.

## Timing
- ready and busy are registered. rdata and rbusy are combinational from raddr, the write ports and the array.
- Sweep length is DEPTH-1 cycles. With ADDR_W=5, ready rises on the 31st rising edge after reset deasserts.
- Write-to-read latency:
  - Forwarding on: 0 cycles, same cycle.
  - Forwarding off: 1 cycle, visible after the edge.
- Set-to-rbusy latency is 1 cycle. Writeback-to-rbusy-clear is 1 cycle, or 0 with forwarding.

## Configuration
- REGFILE_BYPASS_EN, when defined:
  - rdata forwards a same-cycle write (port 1 over port 0).
  - The matching rbusy is masked to 0.
- When undefined:
  - Reads return array contents only; a same-cycle write is visible next cycle.
  - rbusy reflects the registered busy bit only.
  - The pipeline must add a writeback stall or bypass externally.

## Test plan
- Reset then sweep:
  - Pulse reset, then poll ready. Required: ready=0 for 31 cycles, then 1.
  - Every address then reads 0 with rbusy=0, including after junk written to the array before reset.
- Reset mid-sweep:
  - Assert reset at sweep cycle 10. Required: ready stays 0 and the sweep restarts, so ready rises 31 cycles after the second deassert.
- Dual write collision:
  - we0=we1=1, waddr=5, wdata0=0x11111111, wdata1=0x22222222.
  - Required: r5=0x22222222. Same cycle with BYPASS_EN: rdata=0x22222222.
- Register zero:
  - Write 0xDEADBEEF to r0 and set_en to r0. Required: r0 reads 0 and rbusy=0.
- Scoreboard:
  - set_en r7 at cycle t. Required: rbusy=1 at t+1.
  - we0 r7=0xA5A5A5A5 at t+3. Required: rbusy clears at t+4, or at t+3 with bypass. Data is correct.
  - Simultaneous set r7 and write r7. Required: busy stays 1.
- Port scaling:
  - NREAD=4, ADDR_W=3.
  - Required: all four ports independently return the written values.
  - Required: the sweep lasts 7 cycles.
